// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode display.
// Tear-free frame buffer, refresh prescaler, guard blanking.
`timescale 1ns/1ps
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    load_ack,
  output logic [3:0]              nibble,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_pend;
  logic                  r_pend_valid;
  logic [DW-1:0]         r_disp;
  logic [NUM_DIGITS-1:0] r_an;
  logic [3:0]            r_nibble;
  logic                  r_blank;
  logic                  r_ack;
  logic                  r_fs;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_bound;
  logic                  w_xfer;
  logic                  w_guard;
  logic [CW-1:0]         w_presc_nx;
  logic [IW-1:0]         w_idx_nx;
  logic                  w_pend_valid_nx;
  logic [3:0]            w_nib;
  logic                  w_zero;
  logic                  w_supp;
  logic [NUM_DIGITS-1:0] w_an;
  logic                  w_blank;

  always_comb begin
    w_tick     = (r_presc == CW'(REFRESH_DIV - 1));
    w_last     = (r_idx == IW'(NUM_DIGITS - 1));
    w_bound    = w_tick && w_last;
    w_xfer     = w_bound && r_pend_valid;
    w_guard    = (r_presc < CW'(GUARD));
    w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
    w_idx_nx   = r_idx;
    if (w_tick) begin
      w_idx_nx = w_last ? '0 : r_idx + 1'b1;
    end
    // a load on the boundary tick is kept for the next frame
    w_pend_valid_nx = r_pend_valid;
    if (load) begin
      w_pend_valid_nx = 1'b1;
    end else if (w_bound) begin
      w_pend_valid_nx = 1'b0;
    end
  end

  // Walk digits from the top so w_zero means "this and all above are 0"
  always_comb begin
    w_nib  = '0;
    w_supp = 1'b0;
    w_an   = '1;
    w_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero = w_zero && (r_disp[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_nib  = r_disp[4*i +: 4];
        w_supp = (BLANK_LEADING != 0) && (i != 0) && w_zero;
        if (!w_guard) begin
          w_an[i] = 1'b0;
        end
      end
    end
    w_blank = w_guard || w_supp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_disp       <= '0;
      r_an         <= '1;
      r_nibble     <= '0;
      r_blank      <= 1'b1;
      r_ack        <= 1'b0;
      r_fs         <= 1'b0;
    end else begin
      r_presc      <= w_presc_nx;
      r_idx        <= w_idx_nx;
      r_pend_valid <= w_pend_valid_nx;
      if (load) begin
        r_pend <= value;
      end
      if (w_xfer) begin
        r_disp <= r_pend;
      end
      r_an     <= w_an;
      r_nibble <= w_nib;
      r_blank  <= w_blank;
      r_ack    <= w_xfer;
      r_fs     <= w_bound;
    end
  end

  assign load_ack    = r_ack;
  assign nibble      = r_nibble;
  assign blank       = r_blank;
  assign an          = r_an;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: cycle-count model plus
// hand-computed spot checks of each display scenario.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        load_ack;
  logic [3:0]  nibble;
  logic        blank;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // model state: edges since reset, display and pending buffers
  int          m_k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;
  logic [3:0]  e_an;
  logic [3:0]  e_nib;
  logic        e_blank;
  logic        e_ack;
  logic        e_fs;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .GUARD(G),
    .BLANK_LEADING(BL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .value(value),
    .load_ack(load_ack),
    .nibble(nibble),
    .blank(blank),
    .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    int p;
    int d;
    bit bnd;
    if (!rst_n) begin
      m_k     <= 0;
      m_disp  <= '0;
      m_pend  <= '0;
      m_pv    <= 1'b0;
      e_an    <= 4'hF;
      e_nib   <= 4'h0;
      e_blank <= 1'b1;
      e_ack   <= 1'b0;
      e_fs    <= 1'b0;
    end else begin
      p   = m_k % RD;
      d   = (m_k / RD) % ND;
      bnd = (p == RD - 1) && (d == ND - 1);
      e_an    <= (p >= G) ? ~(4'b0001 << d) : 4'hF;
      e_nib   <= 4'((m_disp >> (4 * d)) & 16'hF);
      e_blank <= (p < G) || (BL != 0 && d > 0 && (m_disp >> (4 * d)) == 16'h0);
      e_fs    <= bnd;
      e_ack   <= bnd && m_pv;
      if (bnd && m_pv) m_disp <= m_pend;
      if (load) m_pend <= value;
      m_pv <= load ? 1'b1 : (bnd ? 1'b0 : m_pv);
      m_k  <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("an", an, e_an);
      chk("nibble", nibble, e_nib);
      chk("blank", blank, e_blank);
      chk("load_ack", load_ack, e_ack);
      chk("frame_start", frame_start, e_fs);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < budget);
    chk("frame_start_seen", frame_start, 1'b1);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    step(3);
    mon_en = 1'b1;
    step(1);
    chk("rst_an", an, 4'hF);
    chk("rst_blank", blank, 1'b1);
    chk("rst_nibble", nibble, 4'h0);
    chk("rst_ack", load_ack, 1'b0);
    rst_n = 1'b1;

    // scan order, guard, frame period
    wait_fs(100);
    step(1);  chk("t1_guard_an", an, 4'hF);
    chk("t1_guard_blank", blank, 1'b1);
    step(2);  chk("t1_d0_an", an, 4'hE);
    chk("t1_d0_blank", blank, 1'b0);
    step(8);  chk("t1_d1_an", an, 4'hD);
    chk("t1_d1_blank", blank, 1'b1);
    step(8);  chk("t1_d2_an", an, 4'hB);
    step(8);  chk("t1_d3_an", an, 4'h7);
    step(4);  chk("t1_fs_early", frame_start, 1'b0);
    step(1);  chk("t1_fs_period", frame_start, 1'b1);

    // mid-frame load becomes visible only from digit 0
    step(5);
    pulse_load(16'h1234);
    chk("t2_no_ack_yet", load_ack, 1'b0);
    chk("t2_old_nib", nibble, 4'h0);
    wait_fs(40);
    chk("t2_ack", load_ack, 1'b1);
    step(3);  chk("t2_d0", nibble, 4'h4);
    step(8);  chk("t2_d1", nibble, 4'h3);
    step(8);  chk("t2_d2", nibble, 4'h2);
    step(8);  chk("t2_d3", nibble, 4'h1);

    // leading zero suppression
    pulse_load(16'h0070);
    wait_fs(40);
    chk("t3_ack", load_ack, 1'b1);
    step(3);  chk("t3_d0_nib", nibble, 4'h0);
    chk("t3_d0_blank", blank, 1'b0);
    step(8);  chk("t3_d1_nib", nibble, 4'h7);
    chk("t3_d1_blank", blank, 1'b0);
    step(8);  chk("t3_d2_blank", blank, 1'b1);
    step(8);  chk("t3_d3_blank", blank, 1'b1);
    pulse_load(16'h0000);
    wait_fs(40);
    chk("t3z_ack", load_ack, 1'b1);
    step(3);  chk("t3z_d0_blank", blank, 1'b0);
    chk("t3z_d0_nib", nibble, 4'h0);
    step(8);  chk("t3z_d1_blank", blank, 1'b1);

    // two loads in one frame: last wins, one ack
    pulse_load(16'hAAAA);
    step(3);
    pulse_load(16'h5555);
    wait_fs(40);
    chk("t4_ack", load_ack, 1'b1);
    step(3);  chk("t4_d0", nibble, 4'h5);
    step(8);  chk("t4_d1", nibble, 4'h5);
    wait_fs(40);
    chk("t4_single_ack", load_ack, 1'b0);

    // load on the boundary tick with nothing pending
    step(31);
    load  = 1'b1;
    value = 16'h9876;
    step(1);
    load  = 1'b0;
    chk("t5_fs", frame_start, 1'b1);
    chk("t5_no_ack", load_ack, 1'b0);
    step(3);  chk("t5_old_d0", nibble, 4'h5);
    wait_fs(40);
    chk("t5_late_ack", load_ack, 1'b1);
    step(3);  chk("t5_d0", nibble, 4'h6);
    step(8);  chk("t5_d1", nibble, 4'h7);

    // async reset mid-slot discards the pending load
    step(2);
    pulse_load(16'h4321);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_an", an, 4'hF);
    chk("t6_async_blank", blank, 1'b1);
    chk("t6_async_nib", nibble, 4'h0);
    chk("t6_async_ack", load_ack, 1'b0);
    chk("t6_async_fs", frame_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(40);
    chk("t6_no_ack", load_ack, 1'b0);
    step(3);  chk("t6_d0_nib", nibble, 4'h0);
    chk("t6_d0_blank", blank, 1'b0);
    step(8);  chk("t6_d1_blank", blank, 1'b1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
